// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for univ_shift_reg: command encodings and burst FSM states.
package univ_shift_reg_pkg;

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_LOAD  = 3'b001;
   localparam logic [2:0] MODE_SHL   = 3'b010;
   localparam logic [2:0] MODE_SHR   = 3'b011;
   localparam logic [2:0] MODE_ROL   = 3'b100;
   localparam logic [2:0] MODE_ROR   = 3'b101;
   localparam logic [2:0] MODE_BURST = 3'b110;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } burst_state_e;

endpackage

// File: rtl/univ_shift_burst_ctl.sv
// Burst sequencer: clamps the requested length, counts shift-right steps and
// raises busy/done around the burst. Outputs are registered with the state.
module univ_shift_burst_ctl
   import univ_shift_reg_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [CNT_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             step_o
);

   localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(WIDTH);

   burst_state_e     state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;
   logic             step_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         step_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // A zero-length request is dropped here without a handshake.
               if (start_i && (len_i != '0)) begin
                  state_q <= SHIFT;
                  cnt_q   <= (len_i > MAX_LEN) ? MAX_LEN : len_i;
                  busy_q  <= 1'b1;
                  step_q  <= 1'b1;
               end
            end
            SHIFT: begin
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= DONE;
                  cnt_q   <= '0;
                  done_q  <= 1'b1;
                  step_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               step_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign step_o = step_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift/rotate register with serial burst. Optional parity output
// enabled by defining UNIV_SHIFT_REG_PARITY_EN.
module univ_shift_reg
   import univ_shift_reg_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] x,
   input  logic             sin,
   input  logic [CNT_W-1:0] len,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             sout_vld,
   output logic             busy,
   output logic             done,
   output logic             par
);

   logic [WIDTH-1:0] q_q, q_d;
   logic             sout_q, sout_d;
   logic             vld_q, vld_d;
   logic             step;
   logic             start;

   assign start = en && !busy && (mode == MODE_BURST);

   univ_shift_burst_ctl #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_ctl (
      .clk     (clk),
      .rst     (rst),
      .start_i (start),
      .len_i   (len),
      .busy_o  (busy),
      .done_o  (done),
      .step_o  (step)
   );

   always_comb begin
      q_d    = q_q;
      sout_d = sout_q;
      vld_d  = 1'b0;
      if (step) begin
         q_d    = {sin, q_q[WIDTH-1:1]};
         sout_d = q_q[0];
         vld_d  = 1'b1;
      end else if (en && !busy) begin
         // Burst start itself does not move data; the sequencer takes over.
         case (mode)
            MODE_HOLD: ;
            MODE_LOAD: q_d = x;
            MODE_SHL: begin
               q_d    = {q_q[WIDTH-2:0], sin};
               sout_d = q_q[WIDTH-1];
               vld_d  = 1'b1;
            end
            MODE_SHR: begin
               q_d    = {sin, q_q[WIDTH-1:1]};
               sout_d = q_q[0];
               vld_d  = 1'b1;
            end
            MODE_ROL: begin
               q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
               sout_d = q_q[WIDTH-1];
               vld_d  = 1'b1;
            end
            MODE_ROR: begin
               q_d    = {q_q[0], q_q[WIDTH-1:1]};
               sout_d = q_q[0];
               vld_d  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= '0;
         sout_q <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         sout_q <= sout_d;
         vld_q  <= vld_d;
      end
   end

   assign q        = q_q;
   assign sout     = sout_q;
   assign sout_vld = vld_q;

`ifdef UNIV_SHIFT_REG_PARITY_EN
   logic par_q;

   always_ff @(posedge clk) begin
      if (rst) par_q <= 1'b0;
      else     par_q <= ^q_d;
   end

   assign par = par_q;
`else
   assign par = 1'b0;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=32): per-cycle scoreboard of a
// cycle model plus fixed expected values for the key scenarios.
module tb_univ_shift_reg;

   localparam int W  = 32;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst, en, sin;
   logic [2:0]    mode;
   logic [W-1:0]  x;
   logic [CW-1:0] len;
   logic [W-1:0]  q;
   logic          sout, sout_vld, busy, done, par;

   univ_shift_reg #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .x(x), .sin(sin), .len(len),
      .q(q), .sout(sout), .sout_vld(sout_vld), .busy(busy), .done(done), .par(par)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] q;
      logic         sout, vld, busy, done, par;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // cycle model state
   logic [W-1:0] m_q;
   logic         m_sout, m_vld, m_busy, m_done;
   int           m_st, m_cnt;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model(input logic r, input logic e, input logic [2:0] m,
                        input logic [W-1:0] xv, input logic s, input logic [CW-1:0] l);
      exp_t ex;
      if (r) begin
         m_q = '0; m_sout = 0; m_vld = 0; m_busy = 0; m_done = 0; m_st = 0; m_cnt = 0;
      end else begin
         m_vld = 0;
         case (m_st)
            0: if (e) begin
               case (m)
                  3'b001: m_q = xv;
                  3'b010: begin m_sout = m_q[W-1]; m_q = m_q << 1; m_q[0] = s; m_vld = 1; end
                  3'b011: begin m_sout = m_q[0]; m_q = m_q >> 1; m_q[W-1] = s; m_vld = 1; end
                  3'b100: begin m_sout = m_q[W-1]; m_q = (m_q << 1) | (m_q >> (W-1)); m_vld = 1; end
                  3'b101: begin m_sout = m_q[0]; m_q = (m_q >> 1) | (m_q << (W-1)); m_vld = 1; end
                  3'b110: if (l != 0) begin
                     m_cnt = (int'(l) > W) ? W : int'(l);
                     m_st = 1; m_busy = 1;
                  end
                  default: ;
               endcase
            end
            1: begin
               m_sout = m_q[0]; m_q = m_q >> 1; m_q[W-1] = s; m_vld = 1;
               m_cnt--;
               if (m_cnt == 0) begin m_st = 2; m_done = 1; end
            end
            default: begin m_st = 0; m_busy = 0; m_done = 0; end
         endcase
      end
      ex.q = m_q; ex.sout = m_sout; ex.vld = m_vld; ex.busy = m_busy; ex.done = m_done;
`ifdef UNIV_SHIFT_REG_PARITY_EN
      ex.par = ^m_q;
`else
      ex.par = 1'b0;
`endif
      sb.push_back(ex);
   endtask

   // Drive one cycle, push the model expectation, compare after the edge.
   task automatic cyc(input logic r, input logic e, input logic [2:0] m,
                      input logic [W-1:0] xv, input logic s, input logic [CW-1:0] l);
      exp_t ex;
      rst = r; en = e; mode = m; x = xv; sin = s; len = l;
      model(r, e, m, xv, s, l);
      @(posedge clk);
      #1;
      ex = sb.pop_front();
      chk("q",        q,        ex.q);
      chk("sout",     W'(sout),     W'(ex.sout));
      chk("sout_vld", W'(sout_vld), W'(ex.vld));
      chk("busy",     W'(busy),     W'(ex.busy));
      chk("done",     W'(done),     W'(ex.done));
      chk("par",      W'(par),      W'(ex.par));
   endtask

   task automatic idle(input logic s);
      cyc(1'b0, 1'b0, 3'b000, '0, s, '0);
   endtask

   int n_busy, n_done, n_vld;
   logic [3:0] souts;

   initial begin
      rst = 1; en = 0; mode = 0; x = 0; sin = 0; len = 0;

      // 1: reset then load
      repeat (3) begin
         cyc(1'b1, 1'b0, 3'b000, '0, 1'b0, '0);
         chk("t1_rst_q", q, '0);
         chk("t1_rst_vld", W'(sout_vld), '0);
      end
      cyc(1'b0, 1'b1, 3'b001, 32'd10, 1'b0, '0);
      chk("t1_load_q", q, 32'd10);
      chk("t1_load_vld", W'(sout_vld), '0);

      // 2: load, shift left, rotate right
      cyc(1'b0, 1'b1, 3'b001, 32'd56, 1'b0, '0);
      cyc(1'b0, 1'b1, 3'b010, '0, 1'b1, '0);
      chk("t2_shl_q", q, 32'd113);
      chk("t2_shl_sout", W'(sout), '0);
      chk("t2_shl_vld", W'(sout_vld), 1);
      idle(1'b0);
      chk("t2_vld_drop", W'(sout_vld), '0);
      cyc(1'b0, 1'b1, 3'b101, '0, 1'b0, '0);
      chk("t2_ror_q", q, 32'h8000_0038);
      chk("t2_ror_sout", W'(sout), 1);
      cyc(1'b0, 1'b1, 3'b100, '0, 1'b0, '0);
      cyc(1'b0, 1'b1, 3'b011, '0, 1'b1, '0);
      cyc(1'b0, 1'b1, 3'b111, 32'hDEAD, 1'b0, '0);

      // 3: burst of 4 on 91
      cyc(1'b0, 1'b1, 3'b001, 32'd91, 1'b0, '0);
      cyc(1'b0, 1'b1, 3'b110, '0, 1'b0, CW'(4));
      n_busy = busy ? 1 : 0; n_done = 0; n_vld = 0; souts = '0;
      repeat (6) begin
         idle(1'b0);
         if (busy) n_busy++;
         if (done) n_done++;
         if (sout_vld) begin souts[3 - n_vld] = sout; n_vld++; end
      end
      chk("t3_busy_cycles", W'(n_busy), 5);
      chk("t3_done_pulses", W'(n_done), 1);
      chk("t3_sout_seq", W'(souts), 32'b1101);
      chk("t3_q", q, 32'd5);

      // 4a: zero-length burst
      cyc(1'b0, 1'b1, 3'b110, '0, 1'b1, '0);
      chk("t4_len0_busy", W'(busy), '0);
      idle(1'b0);
      chk("t4_len0_done", W'(done), '0);
      chk("t4_len0_q", q, 32'd5);

      // 4b: over-length burst clamps to 32 steps
      cyc(1'b0, 1'b1, 3'b110, '0, 1'b1, CW'(40));
      n_vld = 0; n_done = 0;
      repeat (36) begin
         idle(1'b1);
         if (sout_vld) n_vld++;
         if (done) n_done++;
      end
      chk("t4_clamp_steps", W'(n_vld), 32);
      chk("t4_clamp_done", W'(n_done), 1);
      chk("t4_clamp_q", q, 32'hFFFF_FFFF);

      // 5: reset mid-burst
      cyc(1'b0, 1'b1, 3'b001, 32'hA5A5_0F0F, 1'b0, '0);
      cyc(1'b0, 1'b1, 3'b110, '0, 1'b0, CW'(8));
      idle(1'b0);
      cyc(1'b1, 1'b0, 3'b000, '0, 1'b0, '0);
      chk("t5_rst_q", q, '0);
      chk("t5_rst_busy", W'(busy), '0);
      chk("t5_rst_done", W'(done), '0);
      n_done = 0;
      repeat (10) begin
         idle(1'b0);
         if (done) n_done++;
      end
      chk("t5_no_done", W'(n_done), '0);
      cyc(1'b0, 1'b1, 3'b001, 32'd10, 1'b0, '0);
      chk("t5_load_after", q, 32'd10);

      // 6: commands ignored while busy
      cyc(1'b0, 1'b1, 3'b001, 32'h1234_5678, 1'b0, '0);
      cyc(1'b0, 1'b1, 3'b110, '0, 1'b0, CW'(8));
      repeat (3) cyc(1'b0, 1'b1, 3'b001, 32'hFFFF_FFFF, 1'b0, CW'(2));
      repeat (7) idle(1'b0);
      chk("t6_q", q, 32'h0012_3456);
      chk("t6_busy", W'(busy), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
